// File: rtl/tbird_seq_lights.sv
// Thunderbird-style tail-light sequencer: N lamps per side,
// thermometer turn sequence, one-step hazard flash, brake overlay.
module tbird_seq_lights #(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               left,
    input  logic               right,
    input  logic               haz,
    input  logic               brake,
    output logic [N_LAMPS-1:0] l_lights,
    output logic [N_LAMPS-1:0] r_lights,
    output logic               busy
);

    localparam int PW = $clog2(N_LAMPS + 1);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LSEQ = 2'd1;
    localparam logic [1:0] RSEQ = 2'd2;
    localparam logic [1:0] HAZ  = 2'd3;

    if (N_LAMPS < 2) begin : g_bad_lamps
        $error("tbird_seq_lights: N_LAMPS must be >= 2");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("tbird_seq_lights: TICK_DIV must be >= 1");
    end

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [N_LAMPS-1:0] l_q, l_d;
    logic [N_LAMPS-1:0] r_q, r_d;
    logic               busy_q, busy_d;
    logic [N_LAMPS-1:0] therm;
    logic [N_LAMPS-1:0] brk;
    logic               tick;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (tick) begin
            unique case (mode_q)
                IDLE: begin
                    if (haz | (left & right)) begin
                        mode_d = HAZ;
                    end else if (left) begin
                        mode_d = LSEQ;
                        pos_d  = PW'(1);
                    end else if (right) begin
                        mode_d = RSEQ;
                        pos_d  = PW'(1);
                    end
                end
                LSEQ, RSEQ: begin
                    if (haz) begin
                        mode_d = HAZ;
                        pos_d  = '0;
                    end else if (pos_q == PW'(N_LAMPS)) begin
                        mode_d = IDLE;
                        pos_d  = '0;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
                HAZ: begin
                    mode_d = IDLE;
                    pos_d  = '0;
                end
            endcase
        end
    end

    // Lamps follow the next state so they change on the same edge as mode.
    always_comb begin
        therm = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            therm[i] = (i < int'(pos_d));
        end
    end

    assign brk = brake ? '1 : '0;

    always_comb begin
        l_d    = brk;
        r_d    = brk;
        busy_d = (mode_d != IDLE);
        unique case (mode_d)
            IDLE: begin
                l_d = brk;
                r_d = brk;
            end
            LSEQ: begin
                l_d = therm;
                r_d = brk;
            end
            RSEQ: begin
                l_d = brk;
                r_d = therm;
            end
            HAZ: begin
                l_d = '1;
                r_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q  <= '0;
            mode_q <= IDLE;
            pos_q  <= '0;
            l_q    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            pos_q  <= pos_d;
            l_q    <= l_d;
            r_q    <= r_d;
            busy_q <= busy_d;
        end
    end

    assign l_lights = l_q;
    assign r_lights = r_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tbird_seq_lights.sv
// Directed bench for tbird_seq_lights: a 3-lamp/div-1 instance
// and a 5-lamp/div-4 instance sharing clock and reset.
module tb_tbird_seq_lights;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    logic a_left = 0, a_right = 0, a_haz = 0, a_brake = 0;
    logic [2:0] a_l, a_r;
    logic a_busy;

    logic b_left = 0, b_right = 0, b_haz = 0, b_brake = 0;
    logic [4:0] b_l, b_r;
    logic b_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tbird_seq_lights #(.N_LAMPS(3), .TICK_DIV(1)) u_a (
        .clk(clk), .rst_b(rst_b),
        .left(a_left), .right(a_right),
        .haz(a_haz), .brake(a_brake),
        .l_lights(a_l), .r_lights(a_r), .busy(a_busy)
    );

    tbird_seq_lights #(.N_LAMPS(5), .TICK_DIV(4)) u_b (
        .clk(clk), .rst_b(rst_b),
        .left(b_left), .right(b_right),
        .haz(b_haz), .brake(b_brake),
        .l_lights(b_l), .r_lights(b_r), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic [2:0] l,
                         input logic [2:0] r, input logic b);
        chk({tag, ".l"}, 32'(a_l), 32'(l));
        chk({tag, ".r"}, 32'(a_r), 32'(r));
        chk({tag, ".busy"}, 32'(a_busy), 32'(b));
    endtask

    initial begin
        logic [4:0] exp_r;
        logic exp_busy;
        int t;

        // reset state
        step();
        step();
        chk_a("rst", 3'b000, 3'b000, 1'b0);
        chk("rst.b.l", 32'(b_l), 0);
        chk("rst.b.r", 32'(b_r), 0);
        chk("rst.b.busy", 32'(b_busy), 0);
        rst_b = 1'b1;
        step();
        chk_a("idle", 3'b000, 3'b000, 1'b0);

        // 1: left pulse for one clock
        a_left = 1;
        step();
        chk_a("t1.e1", 3'b001, 3'b000, 1'b1);
        a_left = 0;
        step();
        chk_a("t1.e2", 3'b011, 3'b000, 1'b1);
        step();
        chk_a("t1.e3", 3'b111, 3'b000, 1'b1);
        step();
        chk_a("t1.e4", 3'b000, 3'b000, 1'b0);

        // 2: hazard during pos=2, held -> alternating flash
        a_left = 1;
        step();
        a_left = 0;
        step();
        chk_a("t2.pos2", 3'b011, 3'b000, 1'b1);
        a_haz = 1;
        step();
        chk_a("t2.haz", 3'b111, 3'b111, 1'b1);
        step();
        chk_a("t2.off", 3'b000, 3'b000, 1'b0);
        step();
        chk_a("t2.on2", 3'b111, 3'b111, 1'b1);
        a_haz = 0;
        step();
        chk_a("t2.end", 3'b000, 3'b000, 1'b0);

        // 3: left & right together -> hazard
        a_left = 1;
        a_right = 1;
        step();
        chk_a("t3.haz", 3'b111, 3'b111, 1'b1);
        a_left = 0;
        a_right = 0;
        step();
        chk_a("t3.end", 3'b000, 3'b000, 1'b0);

        // 5: brake overlay during LSEQ, IDLE and HAZ
        a_left = 1;
        step();
        a_left = 0;
        a_brake = 1;
        step();
        chk_a("t5.brk", 3'b011, 3'b111, 1'b1);
        step();
        chk_a("t5.p3", 3'b111, 3'b111, 1'b1);
        step();
        chk_a("t5.idle", 3'b111, 3'b111, 1'b0);
        a_brake = 0;
        step();
        chk_a("t5.rel", 3'b000, 3'b000, 1'b0);
        a_haz = 1;
        a_brake = 1;
        step();
        chk_a("t5.haz", 3'b111, 3'b111, 1'b1);
        a_haz = 0;
        a_brake = 0;
        step();
        chk_a("t5.end", 3'b000, 3'b000, 1'b0);

        // opposite request mid-sequence is ignored
        a_right = 1;
        step();
        a_right = 0;
        a_left = 1;
        step();
        chk_a("opp", 3'b000, 3'b011, 1'b1);
        a_left = 0;

        // 6: async reset mid-RSEQ at pos=2
        step();
        step();
        a_right = 1;
        step();
        a_right = 0;
        step();
        chk_a("t6.pos2", 3'b000, 3'b011, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk_a("t6.async", 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        step();
        chk_a("t6.after1", 3'b000, 3'b000, 1'b0);
        step();
        chk_a("t6.after2", 3'b000, 3'b000, 1'b0);

        // 4: N=5, DIV=4, right held from reset release
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        b_right = 1;
        for (int k = 1; k <= 28; k++) begin
            step();
            t = k / 4;
            if (t >= 1 && t <= 5) begin
                exp_r = 5'((1 << t) - 1);
                exp_busy = 1'b1;
            end else if (t == 7) begin
                exp_r = 5'b00001;
                exp_busy = 1'b1;
            end else begin
                exp_r = 5'b00000;
                exp_busy = 1'b0;
            end
            chk($sformatf("t4.r%0d", k), 32'(b_r), 32'(exp_r));
            chk($sformatf("t4.busy%0d", k), 32'(b_busy), 32'(exp_busy));
            chk($sformatf("t4.l%0d", k), 32'(b_l), 0);
        end
        b_right = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
